// File: rtl/motor_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_pkg
// Brief    : Constants shared by the motor PWM generator and the PWM speed
//            capture block. Holds speed codes, nominal widths and period,
//            default thresholds, the capture FSM state type and the duty
//            classifier.
// Revision : 1.0 - initial release
// ============================================================================
package motor_pwm_pkg;

  // Speed codes understood by the PWM generator
  localparam logic [2:0] SPD_OFF = 3'd0;
  localparam logic [2:0] SPD_65  = 3'd1;
  localparam logic [2:0] SPD_75  = 3'd2;
  localparam logic [2:0] SPD_85  = 3'd3;
  localparam logic [2:0] SPD_95  = 3'd4;

  // Nominal generator pulse widths and period, in clk cycles
  localparam int unsigned NOM_W_65   = 650000;
  localparam int unsigned NOM_W_75   = 750000;
  localparam int unsigned NOM_W_85   = 850000;
  localparam int unsigned NOM_W_95   = 950000;
  localparam int unsigned NOM_PERIOD = 2097152;

  // Default capture settings; thresholds sit midway between nominal widths
  localparam int unsigned DEF_CNT_W   = 22;
  localparam int unsigned DEF_TIMEOUT = 2200000;
  localparam int unsigned DEF_TH_1    = 325000;
  localparam int unsigned DEF_TH_2    = 700000;
  localparam int unsigned DEF_TH_3    = 800000;
  localparam int unsigned DEF_TH_4    = 900000;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_MEAS_HIGH = 2'd1,
    ST_MEAS_LOW  = 2'd2
  } cap_state_e;

  // Map a measured high time onto a speed code. Lower bounds are inclusive,
  // all compares are unsigned.
  function automatic logic [2:0] classify_duty(
    input logic [31:0] hi,
    input logic [31:0] th1,
    input logic [31:0] th2,
    input logic [31:0] th3,
    input logic [31:0] th4
  );
    logic [2:0] code;
    if (hi < th1) begin
      code = SPD_OFF;
    end else if (hi < th2) begin
      code = SPD_65;
    end else if (hi < th3) begin
      code = SPD_75;
    end else if (hi < th4) begin
      code = SPD_85;
    end else begin
      code = SPD_95;
    end
    return code;
  endfunction

endpackage : motor_pwm_pkg
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : pwm_in_sync
// Brief    : Two-flop synchronizer for the asynchronous PWM line, with
//            single-cycle rise and fall pulses derived against a one-cycle
//            delayed copy of the synchronized level.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Synchronizer chain plus delay stage used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule : pwm_in_sync
`default_nettype wire

// File: rtl/pwm_speed_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_speed_capture
// Brief    : Measures high time and period of an external PWM line in clk
//            cycles, classifies the duty into a 3-bit speed code and flags a
//            line stuck low or high when no rising edge arrives in time.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_speed_capture
  import motor_pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TH_1    = DEF_TH_1,
  parameter int unsigned TH_2    = DEF_TH_2,
  parameter int unsigned TH_3    = DEF_TH_3,
  parameter int unsigned TH_4    = DEF_TH_4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] period_o,
  output logic [2:0]       speed_code_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             stuck_low_o,
  output logic             stuck_high_o
);

  // Counters saturate at the timeout value; the timeout fires on the cycle
  // the period counter steps onto it, so it can only fire once per stall.
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic w_sync;
  logic w_rise;
  logic w_fall;

  pwm_in_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (pwm_in_i),
    .sync_o  (w_sync),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             stuck_low_q, stuck_low_d;
  logic             stuck_high_q, stuck_high_d;

  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_hi_inc;
  logic             w_timeout;
  logic [2:0]       w_code;

  assign w_per_inc = (per_cnt_q != c_timeout) ? per_cnt_q + c_one : per_cnt_q;
  assign w_hi_inc  = (hi_cnt_q != c_timeout) ? hi_cnt_q + c_one : hi_cnt_q;
  assign w_timeout = (per_cnt_q == c_timeout_m1);
  assign w_code    = classify_duty(32'(hi_cnt_q), 32'(TH_1), 32'(TH_2),
                                   32'(TH_3), 32'(TH_4));

  // State, counters and published results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT_RISE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      code_q       <= SPD_OFF;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  // Next-state, counter updates and publish decisions; timeout wins over a rise
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    code_d       = code_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    stuck_low_d  = stuck_low_q;
    stuck_high_d = stuck_high_q;

    if (w_timeout) begin
      state_d      = ST_WAIT_RISE;
      per_cnt_d    = c_timeout;
      hi_cnt_d     = '0;
      high_time_d  = '0;
      period_d     = '0;
      code_d       = SPD_OFF;
      valid_d      = 1'b1;
      locked_d     = 1'b0;
      stuck_high_d = w_sync;
      stuck_low_d  = ~w_sync;
    end else begin
      unique case (state_q)
        ST_WAIT_RISE: begin
          per_cnt_d = w_per_inc;
          // A rise here only arms the measurement; flags stay as they are
          if (w_rise) begin
            state_d   = ST_MEAS_HIGH;
            per_cnt_d = c_one;
            hi_cnt_d  = c_one;
          end
        end
        ST_MEAS_HIGH: begin
          per_cnt_d = w_per_inc;
          // On the fall cycle the high count already equals the high time
          if (w_fall) begin
            state_d = ST_MEAS_LOW;
          end else begin
            hi_cnt_d = w_hi_inc;
          end
        end
        ST_MEAS_LOW: begin
          per_cnt_d = w_per_inc;
          if (w_rise) begin
            state_d      = ST_MEAS_HIGH;
            high_time_d  = hi_cnt_q;
            period_d     = per_cnt_q;
            code_d       = w_code;
            valid_d      = 1'b1;
            locked_d     = 1'b1;
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            per_cnt_d    = c_one;
            hi_cnt_d     = c_one;
          end
        end
        default: begin
          state_d = ST_WAIT_RISE;
        end
      endcase
    end
  end

  assign high_time_o  = high_time_q;
  assign period_o     = period_q;
  assign speed_code_o = code_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign stuck_low_o  = stuck_low_q;
  assign stuck_high_o = stuck_high_q;

endmodule : pwm_speed_capture
`default_nettype wire
